w5300_bus_arbiter: RTL
======================

Name: w5300_bus_arbiter

Overview:
- Round-robin arbiter that shares the single W5300 host-bus access engine between several register-level requesters: common register configuration, per-socket configuration and the runtime socket controllers.
- Each requester presents one transaction per grant: an 11-bit command word (bit 10 = RD/WR flag per W5300 package encoding, bits 9:0 = register address) and write data.
- The arbiter serialises transactions onto the bus engine and returns a one-cycle completion pulse (op_state) to the owner.
- A watchdog aborts a transaction that the bus engine never completes.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYCLES, 16'd1000, clk cycles to wait for bus_done before aborting; 0 disables the watchdog.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- req  input  NUM_REQ  per-requester transaction request, level
- req_addr  input  NUM_REQ x 11  per-requester command word {rw, addr[9:0]}
- req_wr_data  input  NUM_REQ x 16  per-requester write data
- req_op_state  output  NUM_REQ  one-cycle completion pulse to the owning requester
- req_err  output  NUM_REQ  one-cycle timeout pulse, coincident with req_op_state
- req_rd_data  output  16  read data of the last completed transaction, broadcast
- grant  output  NUM_REQ  one-hot current owner; 0 when idle
- busy  output  1  transaction in flight (any state other than Idle)
- bus_start  output  1  one-cycle pulse launching a bus transaction
- bus_addr  output  11  command word to the bus engine
- bus_wr_data  output  16  write data to the bus engine
- bus_done  input  1  one-cycle completion pulse from the bus engine
- bus_rd_data  input  16  read data, valid when bus_done=1

Behaviour:
- Reset values: all outputs 0; state Idle; round-robin pointer last_grant = NUM_REQ-1, so requester 0 has top priority after reset.
- Reset asserted mid-transaction aborts immediately:
  - bus_start drops; no op_state pulse is issued.
  - The bus engine is responsible for its own reset.
- The state machine has four states: Idle, Issue, Wait, Complete.
- Idle:
  - If req != 0, select the first set bit searching upward from last_grant+1, modulo NUM_REQ.
  - Latch the selected index, req_addr[idx] and req_wr_data[idx] into internal registers.
  - Set grant one-hot and go to Issue. Otherwise remain in Idle.
- Issue:
  - bus_start=1 for exactly one cycle.
  - bus_addr and bus_wr_data are driven from the latched registers and held stable through Complete.
  - Clear the watchdog counter and go to Wait.
- Wait:
  - On bus_done: latch bus_rd_data into req_rd_data and go to Complete with err=0.
  - Otherwise, if TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES-1: go to Complete with err=1; req_rd_data is unchanged.
  - Otherwise increment the 16-bit counter, saturating.
  - bus_done and timeout in the same cycle: bus_done wins, err=0.
- Complete:
  - req_op_state[idx]=1 for one cycle; req_err[idx]=err.
  - last_grant <= idx; grant cleared at exit; go to Idle.
- bus_done outside Wait is ignored and causes no state change.
- Latency:
  - req sampled in Idle at cycle T; bus_start at T+1.
  - bus_done at cycle D ≥ T+2 gives op_state at D+1.
  - The next grant decision happens at D+2, so the per-transaction overhead is 3 cycles plus bus latency.
- Requester rules:
  - Requester holds req, req_addr and req_wr_data stable until its op_state pulse.
  - The command is latched at grant, so changes after the grant cycle do not affect the in-flight transaction.
  - req deasserted after grant is ignored; the transaction completes and op_state still pulses.
  - A requester keeping req high after op_state gets a new transaction only when its round-robin turn comes again.
- Fairness: with all requests asserted, grants cycle 0,1,...,NUM_REQ-1,0,...; no requester waits more than NUM_REQ-1 transactions.
- req_rd_data holds its value until the next successful completion; requesters sample it on their op_state pulse.
- bus_addr[10] and all data bits pass through unmodified; the arbiter does not decode RD/WR.

Test Plan:
- Reset → all outputs 0.
- Single request: req=4'b0010, req_addr[1]={WR,10'h200}, wr_data 16'h1234; bus_done 3 cycles after bus_start.
  - Required: bus_start at T+1, bus_addr=11'h600 region value unchanged, grant=4'b0010 during the transaction.
  - Required: req_op_state[1] one cycle after bus_done; other op_state bits 0.
- Round-robin: req=4'b1111 held, bus_done 2 cycles after every bus_start → grant order 0,1,2,3,0 with exactly one op_state per transaction.
- Read path: requester 2 issues RD of Sn_SSR; bus_rd_data=16'h0013 on bus_done.
  - Required: req_rd_data=16'h0013 coincident with req_op_state[2], held through later writes until the next successful completion.
- Timeout: TIMEOUT_CYCLES=50, bus_done never asserted.
  - Required: req_op_state[0] and req_err[0] pulse together at bus_start+51 cycles; req_rd_data unchanged; requester 1 granted next.
- Boundary cases, all in one bench:
  - bus_done in the exact timeout cycle → err=0, data latched.
  - bus_done during Idle → ignored.
  - rst_n low during Wait → all outputs 0 next edge, no op_state, requester 0 first after release.
  - req dropped after grant → op_state still pulses.

Source files
------------

// File: rtl/w5300_bus_arbiter.sv
// Round-robin arbiter that serialises register-level requesters onto the single
// W5300 host-bus engine, with a completion pulse per grant and a bus watchdog.
module w5300_bus_arbiter #(
  parameter int          NUM_REQ        = 4,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd1000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0][10:0]  req_addr,
  input  logic [NUM_REQ-1:0][15:0]  req_wr_data,
  output logic [NUM_REQ-1:0]        req_op_state,
  output logic [NUM_REQ-1:0]        req_err,
  output logic [15:0]               req_rd_data,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      busy,
  output logic                      bus_start,
  output logic [10:0]               bus_addr,
  output logic [15:0]               bus_wr_data,
  input  logic                      bus_done,
  input  logic [15:0]               bus_rd_data
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_COMPLETE} state_t;

  state_t               state_q, state_d;
  logic [IW-1:0]        last_q, last_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [10:0]          addr_q, addr_d;
  logic [15:0]          wdata_q, wdata_d;
  logic [15:0]          rdata_q, rdata_d;
  logic [15:0]          cnt_q, cnt_d;
  logic                 err_q, err_d;

  logic                 sel_found;
  logic [IW-1:0]        sel_idx;
  int                   cand;
  logic                 timeout_hit;

  // Search upward from the requester after the last owner, wrapping around.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = int'(last_q) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!sel_found && req[cand]) begin
        sel_found = 1'b1;
        sel_idx   = IW'(cand);
      end
    end
  end

  assign timeout_hit = (TIMEOUT_CYCLES != 16'd0) && (cnt_q == TIMEOUT_CYCLES - 16'd1);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    idx_d   = idx_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (sel_found) begin
          idx_d   = sel_idx;
          addr_d  = req_addr[sel_idx];
          wdata_d = req_wr_data[sel_idx];
          grant_d = NUM_REQ'(1) << sel_idx;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = 16'd0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus_done) begin
          rdata_d = bus_rd_data;
          err_d   = 1'b0;
          state_d = S_COMPLETE;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = S_COMPLETE;
        end else if (cnt_q != 16'hFFFF) begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_COMPLETE: begin
        last_d  = idx_q;
        grant_d = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      last_q  <= IW'(NUM_REQ - 1);
      idx_q   <= '0;
      grant_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign grant        = grant_q;
  assign busy         = (state_q != S_IDLE);
  assign bus_start    = (state_q == S_ISSUE);
  assign bus_addr     = addr_q;
  assign bus_wr_data  = wdata_q;
  assign req_rd_data  = rdata_q;
  // grant still holds the owner during Complete, so it doubles as the pulse mask.
  assign req_op_state = (state_q == S_COMPLETE) ? grant_q : '0;
  assign req_err      = (state_q == S_COMPLETE && err_q) ? grant_q : '0;

endmodule
